// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: parity codes, frame FSM encodings and default bit timing.
// Used by the TX frame controller and intended for the RX frame controller.
package uart_defs_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 868;   // 100 MHz / 115200 baud
    localparam int DATA_BITS_DEFAULT    = 8;

    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Modes 00 and 11 carry no parity slot.
    function automatic logic has_parity(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
// Latency: tick is combinational from the count; clear forces the count to 0 on the next edge.
// Backpressure: none; free-running while clear is low.
module uart_bit_timer
    import uart_defs_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]   TERM = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] count;

    // Wrapping at TERM doubles as the reset-on-entry for the next bit state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || (count == TERM)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = !clear && (count == TERM);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: start, 8 data bits LSB-first, optional parity, one stop bit.
// Latency: tx/tx_busy registered, start bit appears 1 clock after the accepting edge.
// Backpressure: tx_start ignored while busy (no queuing); tx_done pulses once per frame.
module uart_tx_frame_ctrl
    import uart_defs_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [1:0]           parity_type,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_t          state, state_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic [2:0]           bit_idx, bit_idx_nxt;
    logic [1:0]           mode_q, mode_nxt;
    logic                 par_q, par_nxt;
    logic                 tx_nxt, busy_nxt, done_nxt;
    logic                 tick, timer_clear;

    // Timer is held at zero whenever the FSM is not inside a bit state.
    assign timer_clear = !((state == ST_START) || (state == ST_DATA) ||
                           (state == ST_PARITY) || (state == ST_STOP));

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            mode_q    <= '0;
            par_q     <= 1'b0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_idx   <= bit_idx_nxt;
            mode_q    <= mode_nxt;
            par_q     <= par_nxt;
            tx        <= tx_nxt;
            tx_busy   <= busy_nxt;
            tx_done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_idx_nxt = bit_idx;
        mode_nxt    = mode_q;
        par_nxt     = par_q;
        done_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    state_nxt   = ST_START;
                    shift_nxt   = tx_data;
                    bit_idx_nxt = '0;
                    mode_nxt    = parity_type;
                    par_nxt     = (parity_type == PAR_ODD) ? ~^tx_data : ^tx_data;
                end
            end
            ST_START: begin
                if (tick) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    shift_nxt = shift_reg >> 1;
                    if (bit_idx == LAST_IDX) begin
                        state_nxt = has_parity(mode_q) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (tick) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Line level is derived from where the FSM is going, so tx is registered yet aligned.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = shift_nxt[0];
            ST_PARITY: tx_nxt = par_nxt;
            default:   tx_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule
